mseq_division: RTL

Sequential unsigned restoring divider for the ALU datapath; it computes quotient and remainder of two WIDTH-bit operands one bit per clock. It is the inverse-direction companion of the ripple-carry adder: a borrow-out subtractor replaces the carry chain. The operation issues with a start/busy/done handshake so the ALU controller can share one divider across instructions.

---
 rtl/mseq_div_pkg.sv | 10 +
 rtl/mseq_division_borrow_subtractor.sv | 20 ++
 rtl/mseq_division.sv | 102 ++++++++++
 3 files changed

// File: rtl/mseq_div_pkg.sv
// mseq_div_pkg: shared state encoding, counter sizing and default width for the sequential divider.
package mseq_div_pkg;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/mseq_division_borrow_subtractor.sv
// m_borrow_subtractor: combinational ripple-borrow subtractor, oDiff = iA - iB over WIDTH+1 bits.
module m_borrow_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] iA,
    input  logic [WIDTH:0] iB,
    output logic [WIDTH:0] oDiff,
    output logic           oBorrow
);
    logic [WIDTH+1:0] w_b;

    assign w_b[0] = 1'b0;

    for (genvar g = 0; g <= WIDTH; g++) begin : g_cell
        assign oDiff[g]   = iA[g] ^ iB[g] ^ w_b[g];
        assign w_b[g + 1] = (~iA[g] & iB[g]) | (~(iA[g] ^ iB[g]) & w_b[g]);
    end

    assign oBorrow = w_b[WIDTH + 1];
endmodule

// File: rtl/mseq_division.sv
// mseq_division: restoring unsigned divider, one quotient bit per clock with start/busy/done handshake.
// Define MSEQ_DIV_ZERO_DETECT_EN to short-circuit zero divisors and report them on oDivZero.
module mseq_division
    import mseq_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oQuot,
    output logic [WIDTH-1:0] oRem,
    output logic             oDivZero
);
    localparam int CW = cnt_w(WIDTH);

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q, r_d, r_r, r_quot, r_rem;
    logic [WIDTH:0]   w_shift, w_diff;
    logic             w_borrow, w_accept, w_last, w_unused;

    assign w_accept = iStart && (r_state != ST_RUN);
    assign w_last   = (r_state == ST_RUN) && (r_cnt == CW'(1));
    assign w_shift  = {r_r, r_q[WIDTH-1]};
    // Remainder stays below the divisor, so the difference MSB is always zero when kept.
    assign w_unused = w_diff[WIDTH];

    m_borrow_subtractor #(.WIDTH(WIDTH)) u_sub (
        .iA     (w_shift),
        .iB     ({1'b0, r_d}),
        .oDiff  (w_diff),
        .oBorrow(w_borrow)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_accept)                 w_next = ST_RUN;
        else if (w_last)              w_next = ST_DONE;
        else if (r_state == ST_DONE)  w_next = ST_IDLE;
    end

`ifdef MSEQ_DIV_ZERO_DETECT_EN
    logic r_zero, r_div_zero;
    assign oDivZero = r_div_zero;
`else
    assign oDivZero = 1'b0;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_cnt  <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_r    <= '0;
            r_quot <= '0;
            r_rem  <= '0;
`ifdef MSEQ_DIV_ZERO_DETECT_EN
            r_zero     <= 1'b0;
            r_div_zero <= 1'b0;
`endif
        end else if (w_accept) begin
            r_q   <= iA;
            r_d   <= iB;
            r_r   <= '0;
            r_cnt <= CW'(WIDTH);
`ifdef MSEQ_DIV_ZERO_DETECT_EN
            r_zero <= (iB == '0);
            if (iB == '0) r_cnt <= CW'(1);
`endif
        end else if (r_state == ST_RUN) begin
            r_q   <= {r_q[WIDTH-2:0], ~w_borrow};
            r_r   <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                r_quot <= {r_q[WIDTH-2:0], ~w_borrow};
                r_rem  <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
`ifdef MSEQ_DIV_ZERO_DETECT_EN
                r_div_zero <= r_zero;
                if (r_zero) begin
                    r_quot <= '1;
                    r_rem  <= r_q;
                end
`endif
            end
        end
    end

    assign oBusy = (r_state == ST_RUN);
    assign oDone = (r_state == ST_DONE);
    assign oQuot = r_quot;
    assign oRem  = r_rem;
endmodule
